// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_pkg
// Description : Shared types, line levels and width helper for the console
//               serial transmitter (console_tx_serializer, console_fifo).
// Revision    : 1.0 - initial release
// ============================================================================
package console_pkg;

    // Transmitter FSM states; PARITY is only visited when
    // CONSOLE_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : console_pkg
`default_nettype wire

// File: rtl/console_fifo.sv
`default_nettype none
// ============================================================================
// Module      : console_fifo
// Description : Small power-of-two FIFO buffering console words. A push is
//               accepted only while count < Depth (count before any pop).
//               Full is registered alongside the count.
// Revision    : 1.0 - initial release
// ============================================================================
module console_fifo
    import console_pkg::*;
#(
    parameter int DataSize = 10,
    parameter int Depth    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DataSize-1:0]          data_i,
    output logic [DataSize-1:0]          data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [cnt_width(Depth):0]    count_o
);

    localparam int AW = cnt_width(Depth);
    localparam int CW = AW + 1;

    logic [DataSize-1:0] mem_q [Depth];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                full_q;
    logic                w_push;
    logic                w_pop;

    assign w_push = push_i && (count_q != CW'(Depth));
    assign w_pop  = pop_i  && (count_q != '0);

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    // Storage array needs no reset; only pointers and count carry state.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, count and registered Full; pointers wrap since Depth is 2^n.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(Depth));
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule : console_fifo
`default_nettype wire

// File: rtl/console_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : console_tx_serializer
// Description : Buffers words written on a one-cycle strobe and sends the low
//               CharBits of each as an async serial frame (start, data LSB
//               first, [parity], stop) on the registered Tx line.
//               Optional macro CONSOLE_TX_PARITY_EN adds an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module console_tx_serializer
    import console_pkg::*;
#(
    parameter int DataSize = 10,
    parameter int CharBits = 8,
    parameter int Depth    = 4,
    parameter int ClkDiv   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                write_i,
    input  logic [DataSize-1:0] data_i,
    output logic                full_o,
    output logic                busy_o,
    output logic                overflow_o,
    output logic                tx_o
);

    localparam int BD_W = cnt_width(ClkDiv);
    localparam int BC_W = cnt_width(CharBits);
    localparam int CW   = cnt_width(Depth) + 1;

    tx_state_t           state_q, state_d;
    logic [BD_W-1:0]     baud_q, baud_d;
    logic [BC_W-1:0]     bit_q, bit_d;
    logic [CharBits-1:0] shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                overflow_q;
`ifdef CONSOLE_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic [DataSize-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_after;
    logic                w_push_ok;
    logic                w_pop;
    logic                w_bit_end;

    // Acceptance uses the pre-pop occupancy, so a full FIFO drops the word
    // even on the cycle the head is being popped.
    assign w_push_ok = write_i && !w_full;
    assign w_bit_end = (baud_q == BD_W'(ClkDiv - 1));

    console_fifo #(
        .DataSize (DataSize),
        .Depth    (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (write_i),
        .pop_i   (w_pop),
        .data_i  (data_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Upper word bits are not transmitted.
    generate
        if (CharBits < DataSize) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_head[DataSize-1:CharBits];
        end
    endgenerate

    // State register plus baud/bit counters, shifter and sticky Overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= TX_IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef CONSOLE_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_q | (write_i & w_full);
`ifdef CONSOLE_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next-state logic: frame sequencing on baud-counter bit boundaries.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        w_pop    = 1'b0;
`ifdef CONSOLE_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    shift_d  = w_head[CharBits-1:0];
                    bit_d    = '0;
                    baud_d   = '0;
                    state_d  = START;
`ifdef CONSOLE_TX_PARITY_EN
                    parity_d = ^w_head[CharBits-1:0];
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BC_W'(CharBits - 1)) begin
`ifdef CONSOLE_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef CONSOLE_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Output logic: Tx and Busy are derived from the post-edge state so
    // both registers reflect the cycle that is about to start.
    always_comb begin
        tx_d = TX_IDLE_LEVEL;
        case (state_d)
            START:   tx_d = TX_START_LEVEL;
            DATA:    tx_d = shift_d[0];
`ifdef CONSOLE_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = TX_IDLE_LEVEL;
        endcase
        w_count_after = w_count + CW'(w_push_ok) - CW'(w_pop);
        busy_d        = (state_d != IDLE) || (w_count_after != '0);
    end

    assign full_o     = w_full;
    assign busy_o     = busy_q;
    assign overflow_o = overflow_q;
    assign tx_o       = tx_q;

endmodule : console_tx_serializer
`default_nettype wire

// File: tb/tb_console_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_tx_serializer
// Description : Self-checking bench for console_tx_serializer. A frame-level
//               reference model (word queue + position within frame) predicts
//               Tx, Full, Busy and Overflow every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_tx_serializer;

    localparam int DS    = 10;
    localparam int CB    = 8;
    localparam int DEPTH = 4;
    localparam int CD    = 4;
`ifdef CONSOLE_TX_PARITY_EN
    localparam int FL    = CB + 3;
`else
    localparam int FL    = CB + 2;
`endif

    logic          clk;
    logic          rst;
    logic          write;
    logic [DS-1:0] data;
    logic          full, busy, overflow, tx;

    int checks;
    int errors;

    // Reference model state
    logic [DS-1:0] mq[$];
    bit            m_active;
    int            m_pos;
    bit            m_frame [0:15];
    bit            m_ovf;

    console_tx_serializer #(
        .DataSize (DS),
        .CharBits (CB),
        .Depth    (DEPTH),
        .ClkDiv   (CD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .write_i    (write),
        .data_i     (data),
        .full_o     (full),
        .busy_o     (busy),
        .overflow_o (overflow),
        .tx_o       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_tx();
        return m_active ? m_frame[m_pos / CD] : 1'b1;
    endfunction
    function automatic bit exp_full();
        return mq.size() == DEPTH;
    endfunction
    function automatic bit exp_busy();
        return m_active || (mq.size() != 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge of the reference: frames are a bit list indexed by
    // elapsed cycles / ClkDiv; a finished frame leaves one idle cycle.
    task automatic model_step();
        int            pre_size;
        int            idx;
        logic [DS-1:0] w;
        pre_size = mq.size();
        if (m_active) begin
            m_pos++;
            if (m_pos == FL * CD) m_active = 1'b0;
        end else if (mq.size() != 0) begin
            w = mq.pop_front();
            m_frame[0] = 1'b0;
            for (int i = 0; i < CB; i++) m_frame[i + 1] = w[i];
            idx = CB + 1;
`ifdef CONSOLE_TX_PARITY_EN
            m_frame[idx] = ^w[CB-1:0];
            idx++;
`endif
            m_frame[idx] = 1'b1;
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (write) begin
            if (pre_size < DEPTH) mq.push_back(data);
            else                  m_ovf = 1'b1;
        end
    endtask

    // Advance one clock: model follows the edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; write = 1'b0; data = '0;
        model_reset();
        #3;
        checks++;
        if (tx !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state tx=%b full=%b busy=%b ovf=%b required 1 0 0 0", tx, full, busy, overflow);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle tx=%b busy=%b required 1 0", tx, busy);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] lv;
        int         n;
        lv = 10'b1010101010;
        write = 1'b1; data = 10'h155;
        cycle();
        write = 1'b0;
        n = 0;
        do begin
            checks++;
            if (tx !== exp_tx() || full !== exp_full() || busy !== exp_busy() || overflow !== m_ovf) begin
                errors++;
                $display("FAIL single_frame n=%0d tx=%b/%b full=%b/%b busy=%b/%b ovf=%b/%b", n,
                         tx, exp_tx(), full, exp_full(), busy, exp_busy(), overflow, m_ovf);
            end
            if (m_active && (m_pos % CD == 1) && (m_pos / CD < 9)) begin
                checks++;
                if (tx !== lv[m_pos / CD]) begin
                    errors++;
                    $display("FAIL single_bit idx=%0d tx=%b required %b", m_pos / CD, tx, lv[m_pos / CD]);
                end
            end
            cycle();
            n++;
        end while (exp_busy() && n < 200);
        checks++;
        if (n != FL * CD + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_len busy cycles=%0d required %0d busy=%b", n, FL * CD + 1, busy);
        end
    endtask

    // Writes the listed words on consecutive cycles, then drains with checks.
    task automatic run_words(input string name, input logic [DS-1:0] words [$]);
        int n;
        foreach (words[i]) begin
            write = 1'b1; data = words[i];
            cycle();
            write = 1'b0;
            checks++;
            if (tx !== exp_tx() || full !== exp_full() || busy !== exp_busy() || overflow !== m_ovf) begin
                errors++;
                $display("FAIL %s_wr i=%0d tx=%b/%b full=%b/%b busy=%b/%b ovf=%b/%b", name, i,
                         tx, exp_tx(), full, exp_full(), busy, exp_busy(), overflow, m_ovf);
            end
        end
        n = 0;
        while (exp_busy() && n < 3000) begin
            cycle();
            n++;
            checks++;
            if (tx !== exp_tx() || full !== exp_full() || busy !== exp_busy() || overflow !== m_ovf) begin
                errors++;
                $display("FAIL %s n=%0d tx=%b/%b full=%b/%b busy=%b/%b ovf=%b/%b", name, n,
                         tx, exp_tx(), full, exp_full(), busy, exp_busy(), overflow, m_ovf);
            end
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_queueing();
        logic [DS-1:0] w [$];
        w = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
        run_words("queueing", w);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL queue_ovf overflow=%b required 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [DS-1:0] w [$];
        w = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h0AA};
        run_words("overflow", w);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky overflow=%b required 1", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        foreach (mq[i]) ; // model queue is empty here after the drain
        for (int i = 0; i < 3; i++) begin
            write = 1'b1; data = DS'($urandom);
            cycle();
        end
        write = 1'b0;
        n = 0;
        while (!(m_active && m_pos == CD * 4 + 1) && n < 500) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (tx !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid tx=%b full=%b busy=%b ovf=%b required 1 0 0 0", tx, full, busy, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3 * FL * CD; k++) begin
            cycle();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet k=%0d tx=%b busy=%b full=%b required 1 0 0", k, tx, busy, full);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 600; k++) begin
            write = ($urandom_range(0, 15) < 3);
            data  = DS'($urandom);
            cycle();
            checks++;
            if (tx !== exp_tx() || full !== exp_full() || busy !== exp_busy() || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random k=%0d tx=%b/%b full=%b/%b busy=%b/%b ovf=%b/%b", k,
                         tx, exp_tx(), full, exp_full(), busy, exp_busy(), overflow, m_ovf);
            end
        end
        write = 1'b0;
        n = 0;
        while (exp_busy() && n < 3000) begin
            cycle();
            n++;
            checks++;
            if (tx !== exp_tx() || busy !== exp_busy()) begin
                errors++;
                $display("FAIL random_drain n=%0d tx=%b/%b busy=%b/%b", n, tx, exp_tx(), busy, exp_busy());
            end
        end
    endtask

`ifdef CONSOLE_TX_PARITY_EN
    task automatic test_parity(input logic [DS-1:0] word, input bit par);
        int n;
        write = 1'b1; data = word;
        cycle();
        write = 1'b0;
        n = 0;
        while (exp_busy() && n < 500) begin
            cycle();
            n++;
            checks++;
            if (tx !== exp_tx()) begin
                errors++;
                $display("FAIL parity_frame n=%0d tx=%b required %b", n, tx, exp_tx());
            end
            if (m_active && m_pos == CD * (CB + 1) + 1) begin
                checks++;
                if (tx !== par) begin
                    errors++;
                    $display("FAIL parity_bit word=%h tx=%b required %b", word, tx, par);
                end
            end
        end
        checks++;
        if (n != FL * CD + 1) begin
            errors++;
            $display("FAIL parity_len cycles=%0d required %0d", n, FL * CD + 1);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_frame();
        test_queueing();
        test_overflow();
        test_reset_mid_frame();
        test_random();
`ifdef CONSOLE_TX_PARITY_EN
        test_parity(10'h007, 1'b1);
        test_parity(10'h003, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_console_tx_serializer
`default_nettype wire
